// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - NCH-channel arbiter serialising 1/2/4-byte accesses onto a byte-wide RAM port
//
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration; fixed priority when undefined).
//
// Ports:
//   clock, reset       clock and synchronous active-high reset
//   ch_req/ch_we       per-channel request and write select
//   ch_addr/ch_wdata   per-channel byte address and write data (channel k in slice k)
//   ch_len/ch_signed   per-channel transfer length code and sign-extension select
//   ch_ready           one-hot, one-cycle completion pulse
//   ch_rdata           shared read result, held until the next read completes
//   ram_rw/ram_addr    byte RAM port control and address
//   ram_w_data         byte RAM write data
//   ram_r_data         byte RAM read data, valid RD_LAT edges after ram_addr
//   busy               high while a transfer is in flight
module mem_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_we,
    input  logic [NCH*ADDR_W-1:0] ch_addr,
    input  logic [NCH*32-1:0]     ch_wdata,
    input  logic [NCH*3-1:0]      ch_len,
    input  logic [NCH-1:0]        ch_signed,
    output logic [NCH-1:0]        ch_ready,
    output logic [31:0]           ch_rdata,
    output logic                  ram_rw,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_w_data,
    input  logic [7:0]            ram_r_data,
    output logic                  busy
);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state, state_next;
    logic              win_valid, accept, done;
    logic [IDX_W-1:0]  win_idx, ch_idx;
    logic [ADDR_W-1:0] sel_addr, addr_r;
    logic [31:0]       sel_wdata, wdata_r, rbuf, raw, ext;
    logic [2:0]        sel_len_code, sel_len, len_r;
    logic              signed_r;
    // cyc counts edges since the accept edge; it drives both the issue index
    // (cyc) and the capture index (cyc - RD_LAT) so one counter serves both.
    logic [3:0]        cyc, cap_idx;
    logic              cap_hit, cap_last;

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0]  rr_ptr;
`endif

    // Arbitration
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
`ifdef MEM_ARB_RR_EN
        for (int off = 0; off < NCH; off++) begin
            int c;
            c = (int'(rr_ptr) + off) % NCH;
            if (!win_valid && ch_req[c]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
`else
        // Walk downwards so the lowest requesting index is the one left standing.
        for (int c = NCH - 1; c >= 0; c--) begin
            if (ch_req[c]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
`endif
    end

    always_comb begin
        sel_addr     = ch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        sel_wdata    = ch_wdata[int'(win_idx)*32 +: 32];
        sel_len_code = ch_len[int'(win_idx)*3 +: 3];
        casez (sel_len_code)
            3'b1??:  sel_len = 3'd4;
            3'b01?:  sel_len = 3'd2;
            default: sel_len = 3'd1;
        endcase
    end

    assign cap_hit  = (cyc >= 4'(RD_LAT));
    assign cap_idx  = cyc - 4'(RD_LAT);
    assign cap_last = cap_hit && (cap_idx == ({1'b0, len_r} - 4'd1));

    // Final byte comes straight from the RAM so the result registers on the capture edge.
    always_comb begin
        raw = rbuf;
        raw[{cap_idx[1:0], 3'b000} +: 8] = ram_r_data;
        case (len_r)
            3'd4:    ext = raw;
            3'd2:    ext = {{16{signed_r & raw[15]}}, raw[15:0]};
            default: ext = {{24{signed_r & raw[7]}}, raw[7:0]};
        endcase
    end

    // FSM
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (win_valid) begin
                accept     = 1'b1;
                state_next = ch_we[win_idx] ? WR : RD;
            end
            WR: if (cyc == {1'b0, len_r}) begin
                done       = 1'b1;
                state_next = IDLE;
            end
            RD: if (cap_last) begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            ch_ready   <= '0;
            ch_rdata   <= '0;
            ram_rw     <= 1'b0;
            ram_addr   <= '0;
            ram_w_data <= '0;
            busy       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            len_r      <= 3'd1;
            signed_r   <= 1'b0;
            ch_idx     <= '0;
            cyc        <= '0;
            rbuf       <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr     <= '0;
`endif
        end else begin
            ch_ready <= '0;
            if (accept) begin
                addr_r     <= sel_addr;
                wdata_r    <= sel_wdata;
                len_r      <= sel_len;
                signed_r   <= ch_signed[win_idx];
                ch_idx     <= win_idx;
                cyc        <= 4'd1;
                ram_addr   <= sel_addr;
                ram_w_data <= sel_wdata[7:0];
                ram_rw     <= ch_we[win_idx];
                busy       <= 1'b1;
`ifdef MEM_ARB_RR_EN
                rr_ptr     <= (win_idx == IDX_W'(NCH - 1)) ? '0 : win_idx + 1'b1;
`endif
            end else if (state == WR) begin
                if (done) begin
                    ram_rw           <= 1'b0;
                    ch_ready[ch_idx] <= 1'b1;
                    busy             <= 1'b0;
                end else begin
                    ram_addr   <= addr_r + ADDR_W'(cyc);
                    ram_w_data <= wdata_r[{cyc[1:0], 3'b000} +: 8];
                    cyc        <= cyc + 4'd1;
                end
            end else if (state == RD) begin
                if (cyc < {1'b0, len_r})
                    ram_addr <= addr_r + ADDR_W'(cyc);
                if (cap_hit)
                    rbuf[{cap_idx[1:0], 3'b000} +: 8] <= ram_r_data;
                if (done) begin
                    ch_rdata         <= ext;
                    ch_ready[ch_idx] <= 1'b1;
                    busy             <= 1'b0;
                end
                cyc <= cyc + 4'd1;
            end
        end
    end
endmodule
